// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared PS/2 definitions: frame-level state encoding and the
//               odd-parity helper used by host transmitter and receivers.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_REQ       = 3'd2,
        ST_DATA      = 3'd3,
        ST_PARITY    = 3'd4,
        ST_STOP      = 3'd5,
        ST_ACK       = 3'd6,
        ST_WAIT_IDLE = 3'd7
    } ps2_state_e;

    // PS/2 parity bit makes the total count of ones in data+parity odd.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : ps2_sync_edge
// Description : Two-flop synchroniser for an asynchronous PS/2 line plus a
//               falling-edge detector on the synchronised level.
//   clk   - system clock
//   rst_n - asynchronous active-low reset (line assumed idle-high)
//   din   - raw asynchronous line level
//   sync  - synchronised line level
//   fall  - one-cycle strobe: synchronised level went 1 -> 0
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic sync,
    output logic fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= din;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign sync = r_sync;
    assign fall = r_prev & ~r_sync;

endmodule
`default_nettype wire

// File: rtl/ps2_host_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : ps2_host_transmitter
// Description : PS/2 host-to-device byte transmitter. Inhibits the bus,
//               issues a request-to-send, shifts out 8 data bits LSB first,
//               odd parity and stop on device clock falling edges, then
//               checks the device acknowledge.
//   INHIBIT_CYC - clk cycles PS/2 clock is held low before the start bit
//   TIMEOUT_CYC - max clk cycles between expected device clock edges
//   clk, rst_n  - system clock, asynchronous active-low reset
//   tx_data/tx_valid/tx_ready   - byte request handshake
//   ps2_clk_i/ps2_data_i        - raw PS/2 line levels
//   ps2_clk_oe/ps2_data_oe      - open-drain pull-low enables
//   done/ack_err/timeout_err    - single-cycle status pulses
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_host_transmitter
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYC = 5000,
    parameter int TIMEOUT_CYC = 750000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       done,
    output logic       ack_err,
    output logic       timeout_err
);

    localparam int c_INH_W = $clog2(INHIBIT_CYC + 1);
    localparam int c_TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_INH_W-1:0] c_INH_LAST = c_INH_W'(INHIBIT_CYC - 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYC - 1);

    ps2_state_e         r_state,     w_state_next;
    logic [7:0]         r_byte,      w_byte_next;
    logic               r_parity,    w_parity_next;
    logic [2:0]         r_bit_cnt,   w_bit_cnt_next;
    logic [c_INH_W-1:0] r_inh_cnt,   w_inh_cnt_next;
    logic [c_TMO_W-1:0] r_tmo_cnt,   w_tmo_cnt_next;
    logic               r_clk_oe,    w_clk_oe_next;
    logic               r_data_oe,   w_data_oe_next;
    logic               r_done,      w_done_next;
    logic               r_ack_err,   w_ack_err_next;
    logic               r_tmo_err,   w_tmo_err_next;

    logic w_clk_sync;
    logic w_clk_fall;
    logic r_data_meta;
    logic r_data_sync;
    logic w_in_frame;
    logic w_activity;

    ps2_sync_edge u_clk_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (ps2_clk_i),
        .sync  (w_clk_sync),
        .fall  (w_clk_fall)
    );

    // Data line only needs its level, so no edge detector here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_meta <= 1'b1;
            r_data_sync <= 1'b1;
        end else begin
            r_data_meta <= ps2_data_i;
            r_data_sync <= r_data_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_byte    <= '0;
            r_parity  <= 1'b0;
            r_bit_cnt <= '0;
            r_inh_cnt <= '0;
            r_tmo_cnt <= '0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_done    <= 1'b0;
            r_ack_err <= 1'b0;
            r_tmo_err <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_byte    <= w_byte_next;
            r_parity  <= w_parity_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_inh_cnt <= w_inh_cnt_next;
            r_tmo_cnt <= w_tmo_cnt_next;
            r_clk_oe  <= w_clk_oe_next;
            r_data_oe <= w_data_oe_next;
            r_done    <= w_done_next;
            r_ack_err <= w_ack_err_next;
            r_tmo_err <= w_tmo_err_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_byte_next    = r_byte;
        w_parity_next  = r_parity;
        w_bit_cnt_next = r_bit_cnt;
        w_inh_cnt_next = r_inh_cnt;
        w_clk_oe_next  = r_clk_oe;
        w_data_oe_next = r_data_oe;
        w_done_next    = 1'b0;
        w_ack_err_next = 1'b0;
        w_tmo_err_next = 1'b0;

        w_in_frame = (r_state != ST_IDLE) && (r_state != ST_INHIBIT);
        // While waiting for the bus to go idle, "progress" is both lines high
        // rather than a clock edge.
        w_activity = (r_state == ST_WAIT_IDLE) ? (w_clk_sync & r_data_sync)
                                                : w_clk_fall;

        case (r_state)
            ST_IDLE: begin
                w_clk_oe_next  = 1'b0;
                w_data_oe_next = 1'b0;
                if (tx_valid) begin
                    w_byte_next    = tx_data;
                    w_parity_next  = odd_parity(tx_data);
                    w_inh_cnt_next = '0;
                    w_clk_oe_next  = 1'b1;
                    w_state_next   = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (r_inh_cnt == c_INH_LAST) begin
                    w_clk_oe_next  = 1'b0;
                    w_data_oe_next = 1'b1;
                    w_state_next   = ST_REQ;
                end else begin
                    w_inh_cnt_next = r_inh_cnt + c_INH_W'(1);
                end
            end
            ST_REQ: begin
                if (w_clk_fall) begin
                    w_data_oe_next = ~r_byte[0];
                    w_bit_cnt_next = '0;
                    w_state_next   = ST_DATA;
                end
            end
            ST_DATA: begin
                // r_bit_cnt is the index of the bit currently on the line.
                if (w_clk_fall) begin
                    if (r_bit_cnt == 3'd7) begin
                        w_data_oe_next = ~r_parity;
                        w_state_next   = ST_PARITY;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 3'd1;
                        w_data_oe_next = ~r_byte[r_bit_cnt + 3'd1];
                    end
                end
            end
            ST_PARITY: begin
                if (w_clk_fall) begin
                    w_data_oe_next = 1'b0;
                    w_state_next   = ST_STOP;
                end
            end
            ST_STOP: begin
                // Stop bit is already on the line; the next device falling
                // edge is the acknowledge clock, handled in ST_ACK.
                w_state_next = ST_ACK;
            end
            ST_ACK: begin
                if (w_clk_fall) begin
                    w_ack_err_next = r_data_sync;
                    w_state_next   = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (w_clk_sync && r_data_sync) begin
                    w_done_next  = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        if (w_in_frame && !w_activity && (r_tmo_cnt == c_TMO_LAST)) begin
            w_state_next   = ST_IDLE;
            w_clk_oe_next  = 1'b0;
            w_data_oe_next = 1'b0;
            w_done_next    = 1'b0;
            w_ack_err_next = 1'b0;
            w_tmo_err_next = 1'b1;
        end

        if (!w_in_frame || w_activity || (w_state_next != r_state)) begin
            w_tmo_cnt_next = '0;
        end else begin
            w_tmo_cnt_next = r_tmo_cnt + c_TMO_W'(1);
        end
    end

    assign tx_ready    = (r_state == ST_IDLE);
    assign ps2_clk_oe  = r_clk_oe;
    assign ps2_data_oe = r_data_oe;
    assign done        = r_done;
    assign ack_err     = r_ack_err;
    assign timeout_err = r_tmo_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_host_transmitter
// Description : Self-checking bench for ps2_host_transmitter with a PS/2
//               device model (40-cycle clock period) and a frame model that
//               derives the expected data/parity/stop bits from the byte.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_host_transmitter;

    localparam int INHIBIT_CYC = 20;
    localparam int TIMEOUT_CYC = 200;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       done;
    logic       ack_err;
    logic       timeout_err;

    logic dev_clk_low = 1'b0;
    logic dev_data_low = 1'b0;
    wire  ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
    wire  ps2_data_line = ~(ps2_data_oe | dev_data_low);

    int tests_run = 0;
    int tests_failed = 0;
    int cnt_done = 0;
    int cnt_ack = 0;
    int cnt_tmo = 0;
    int pulse_viol = 0;
    logic prev_done = 1'b0;
    logic prev_ack = 1'b0;
    logic prev_tmo = 1'b0;
    bit stop_scramble = 1'b0;

    always #5 clk = ~clk;

    ps2_host_transmitter #(
        .INHIBIT_CYC (INHIBIT_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .ps2_clk_i   (ps2_clk_line),
        .ps2_data_i  (ps2_data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .done        (done),
        .ack_err     (ack_err),
        .timeout_err (timeout_err)
    );

    // Status pulse monitor.
    always @(negedge clk) begin
        if (done === 1'b1) cnt_done++;
        if (ack_err === 1'b1) cnt_ack++;
        if (timeout_err === 1'b1) cnt_tmo++;
        if ((done === 1'b1 && prev_done) || (ack_err === 1'b1 && prev_ack) ||
            (timeout_err === 1'b1 && prev_tmo) || (done === 1'b1 && timeout_err === 1'b1))
            pulse_viol++;
        prev_done = (done === 1'b1);
        prev_ack  = (ack_err === 1'b1);
        prev_tmo  = (timeout_err === 1'b1);
    end

    // Expected 10 device-visible bits after the start bit: data LSB first,
    // odd parity, stop. Packed as {stop, parity, data}.
    function automatic logic [9:0] frame_model(input logic [7:0] b);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) if (b[i]) ones++;
        return {1'b1, (ones % 2 == 0), b};
    endfunction

    // Requests a byte and plays the device: measures inhibit length, reads
    // the start bit, generates n_clk clock pulses and samples each bit in the
    // high phase. With n_clk == 11 it also waits for the done pulse.
    task automatic send_frame(input logic [7:0] b, input bit ack, input int n_clk,
                              input bit keep_valid, output int inh_len,
                              output logic start_bit, output logic [9:0] rx, output bit ok);
        int w;
        int d0;
        ok = 1'b1;
        inh_len = 0;
        rx = '0;
        d0 = cnt_done;
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        if (!keep_valid) tx_valid = 1'b0;
        while (ps2_clk_oe === 1'b1 && inh_len < 1000) begin
            inh_len++;
            @(posedge clk); #1;
        end
        start_bit = ps2_data_line;
        repeat (10) @(posedge clk);
        for (int i = 1; i <= n_clk; i++) begin
            @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (20) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (10) @(negedge clk);
            if (i <= 10) rx[i-1] = ps2_data_line;
            if (i == 10 && ack) dev_data_low = 1'b1;
            repeat (10) @(negedge clk);
        end
        dev_data_low = 1'b0;
        if (n_clk == 11) begin
            w = 0;
            while (done !== 1'b1 && cnt_done == d0 && w < 300) begin
                @(posedge clk); #1;
                w++;
            end
            if (done !== 1'b1 && cnt_done == d0) ok = 1'b0;
            tx_valid = 1'b0;
            @(negedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_oe: got %b expected 00", {ps2_clk_oe, ps2_data_oe});
        end
        tests_run++;
        if ({done, ack_err, timeout_err} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_pulses: got %b expected 000", {done, ack_err, timeout_err});
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if (tx_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_tx_ready: got %b expected 1", tx_ready);
        end
    endtask

    task automatic test_frame_ed();
        int inh; logic sb; logic [9:0] rx; bit ok; int d0; int a0;
        d0 = cnt_done; a0 = cnt_ack;
        send_frame(8'hED, 1'b1, 11, 1'b0, inh, sb, rx, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL ed_done_wait: done not seen within bound"); end
        tests_run++;
        if (inh != INHIBIT_CYC) begin
            tests_failed++; $display("FAIL ed_inhibit_len: got %0d expected %0d", inh, INHIBIT_CYC);
        end
        tests_run++;
        if (sb !== 1'b0) begin tests_failed++; $display("FAIL ed_start_bit: got %b expected 0", sb); end
        tests_run++;
        if (rx !== frame_model(8'hED)) begin
            tests_failed++; $display("FAIL ed_bits: got %b expected %b", rx, frame_model(8'hED));
        end
        tests_run++;
        if (cnt_done - d0 != 1 || cnt_ack - a0 != 0) begin
            tests_failed++;
            $display("FAIL ed_status: done %0d ack_err %0d expected 1 and 0", cnt_done - d0, cnt_ack - a0);
        end
        tests_run++;
        if ({ps2_clk_oe, ps2_data_oe, tx_ready} !== 3'b001) begin
            tests_failed++;
            $display("FAIL ed_release: oe/ready got %b expected 001", {ps2_clk_oe, ps2_data_oe, tx_ready});
        end
    endtask

    task automatic test_parity();
        logic [7:0] bytes [2];
        logic       par [2];
        int inh; logic sb; logic [9:0] rx; bit ok;
        bytes = '{8'h01, 8'h00};
        par   = '{1'b0, 1'b1};
        for (int k = 0; k < 2; k++) begin
            send_frame(bytes[k], 1'b1, 11, 1'b0, inh, sb, rx, ok);
            tests_run++;
            if (rx[8] !== par[k] || !ok) begin
                tests_failed++;
                $display("FAIL parity_%02h: got %b ok=%0d expected %b", bytes[k], rx[8], ok, par[k]);
            end
            tests_run++;
            if (rx !== frame_model(bytes[k])) begin
                tests_failed++;
                $display("FAIL bytes_%02h: got %b expected %b", bytes[k], rx, frame_model(bytes[k]));
            end
        end
    endtask

    task automatic test_random_bytes();
        int inh; logic sb; logic [9:0] rx; bit ok; logic [7:0] b; int d0;
        for (int k = 0; k < 4; k++) begin
            b = 8'($urandom);
            d0 = cnt_done;
            send_frame(b, 1'b1, 11, 1'b0, inh, sb, rx, ok);
            tests_run++;
            if (rx !== frame_model(b) || cnt_done - d0 != 1 || !ok) begin
                tests_failed++;
                $display("FAIL random_%02h: got %b done %0d expected %b done 1",
                         b, rx, cnt_done - d0, frame_model(b));
            end
        end
    endtask

    task automatic test_no_ack();
        int inh; logic sb; logic [9:0] rx; bit ok; int d0; int a0; int t0;
        d0 = cnt_done; a0 = cnt_ack; t0 = cnt_tmo;
        send_frame(8'h5A, 1'b0, 11, 1'b0, inh, sb, rx, ok);
        tests_run++;
        if (cnt_ack - a0 != 1 || cnt_done - d0 != 1 || cnt_tmo - t0 != 0 || !ok) begin
            tests_failed++;
            $display("FAIL no_ack_status: ack_err %0d done %0d timeout %0d expected 1 1 0",
                     cnt_ack - a0, cnt_done - d0, cnt_tmo - t0);
        end
        tests_run++;
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin
            tests_failed++;
            $display("FAIL no_ack_release: got %b expected 00", {ps2_clk_oe, ps2_data_oe});
        end
    endtask

    task automatic test_timeout();
        int w; int n; int d0; int t0;
        d0 = cnt_done; t0 = cnt_tmo;
        @(negedge clk);
        tx_data  = 8'($urandom);
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        w = 0;
        while (ps2_clk_oe === 1'b1 && w < 100) begin @(posedge clk); #1; w++; end
        tests_run++;
        if (ps2_data_oe !== 1'b1) begin
            tests_failed++; $display("FAIL tmo_req_start: data_oe got %b expected 1", ps2_data_oe);
        end
        n = 0;
        while (timeout_err !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
        tests_run++;
        if (n != TIMEOUT_CYC) begin
            tests_failed++; $display("FAIL tmo_latency: got %0d cycles expected %0d", n, TIMEOUT_CYC);
        end
        tests_run++;
        if ({ps2_clk_oe, ps2_data_oe, tx_ready} !== 3'b001) begin
            tests_failed++;
            $display("FAIL tmo_release: oe/ready got %b expected 001", {ps2_clk_oe, ps2_data_oe, tx_ready});
        end
        repeat (5) @(negedge clk);
        #1;
        tests_run++;
        if (cnt_tmo - t0 != 1 || cnt_done - d0 != 0) begin
            tests_failed++;
            $display("FAIL tmo_status: timeout %0d done %0d expected 1 0", cnt_tmo - t0, cnt_done - d0);
        end
    endtask

    task automatic test_reset_midframe();
        int inh; logic sb; logic [9:0] rx; bit ok; logic [7:0] b; int d0; int a0; int t0;
        b = 8'($urandom) & 8'hEF;
        d0 = cnt_done; a0 = cnt_ack; t0 = cnt_tmo;
        send_frame(b, 1'b1, 5, 1'b0, inh, sb, rx, ok);
        tests_run++;
        if (ps2_data_oe !== 1'b1) begin
            tests_failed++; $display("FAIL mid_bit4: data_oe got %b expected 1", ps2_data_oe);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin
            tests_failed++; $display("FAIL mid_reset_oe: got %b expected 00", {ps2_clk_oe, ps2_data_oe});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (TIMEOUT_CYC + 50) @(negedge clk);
        #1;
        tests_run++;
        if (cnt_done != d0 || cnt_ack != a0 || cnt_tmo != t0) begin
            tests_failed++;
            $display("FAIL mid_no_pulses: done %0d ack_err %0d timeout %0d expected 0 0 0",
                     cnt_done - d0, cnt_ack - a0, cnt_tmo - t0);
        end
        send_frame(8'hF4, 1'b1, 11, 1'b0, inh, sb, rx, ok);
        tests_run++;
        if (rx !== frame_model(8'hF4) || cnt_done - d0 != 1 || !ok) begin
            tests_failed++;
            $display("FAIL mid_resend_f4: got %b done %0d expected %b done 1",
                     rx, cnt_done - d0, frame_model(8'hF4));
        end
    endtask

    task automatic test_hold_valid();
        int inh; logic sb; logic [9:0] rx; bit ok; logic [7:0] b; int d0;
        b = 8'($urandom);
        d0 = cnt_done;
        stop_scramble = 1'b0;
        fork
            begin
                wait (ps2_clk_oe === 1'b1);
                while (!stop_scramble) begin
                    @(negedge clk);
                    tx_data = 8'($urandom);
                end
            end
        join_none
        send_frame(b, 1'b1, 11, 1'b1, inh, sb, rx, ok);
        stop_scramble = 1'b1;
        tests_run++;
        if (rx !== frame_model(b) || cnt_done - d0 != 1 || !ok) begin
            tests_failed++;
            $display("FAIL hold_valid_bits: got %b done %0d expected %b done 1",
                     rx, cnt_done - d0, frame_model(b));
        end
        repeat (5) @(negedge clk);
        tests_run++;
        if (ps2_clk_oe !== 1'b0 || tx_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL hold_valid_idle: clk_oe %b tx_ready %b expected 0 1", ps2_clk_oe, tx_ready);
        end
    endtask

    task automatic test_pulse_rules();
        tests_run++;
        if (pulse_viol != 0) begin
            tests_failed++;
            $display("FAIL pulse_rules: got %0d violations expected 0", pulse_viol);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_frame_ed();
        test_parity();
        test_random_bytes();
        test_no_ack();
        test_timeout();
        test_reset_midframe();
        test_hold_valid();
        test_pulse_rules();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #(10 * 80000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/ps2_host_transmitter.md
PS2_HOST_TRANSMITTER -- requirements
Module: ps2_host_transmitter

Interface
REQ-001 SHALL have parameter INHIBIT_CYC, default 5000, clk cycles the host holds PS/2 clock low before the start bit (100 us at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 750000, maximum clk cycles allowed between consecutive expected PS/2 clock falling edges (15 ms at 50 MHz).
REQ-003 SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port tx_data, input, 8, byte to send to the device.
REQ-006 SHALL have port tx_valid, input, 1, request to send tx_data.
REQ-007 SHALL have port tx_ready, output, 1, high when a new byte can be accepted.
REQ-008 SHALL have ports ps2_clk_i and ps2_data_i, input, 1 each, raw asynchronous PS/2 line levels.
REQ-009 SHALL have ports ps2_clk_oe and ps2_data_oe, output, 1 each; 1 = pull line low, 0 = release (open-drain).
REQ-010 SHALL have ports done, ack_err, timeout_err, output, 1 each, single-cycle completion/status pulses.

Function
REQ-011 SHALL synchronise ps2_clk_i and ps2_data_i through two flops each; a falling edge is synced clock previously 1 and now 0.
REQ-012 SHALL accept a byte on a clk edge where tx_valid and tx_ready are both 1, capturing tx_data and odd parity (~^tx_data); tx_ready SHALL be 1 only in IDLE.
REQ-013 SHALL ignore tx_valid while tx_ready is 0; no queuing.
REQ-014 States: IDLE, INHIBIT, REQ, DATA, PARITY, STOP, ACK, WAIT_IDLE.
REQ-015 IDLE: both oe 0; on accept go to INHIBIT with ps2_clk_oe=1 on the next cycle.
REQ-016 INHIBIT: hold ps2_clk_oe=1 for exactly INHIBIT_CYC cycles, then set ps2_data_oe=1 (start bit 0), ps2_clk_oe=0, go to REQ.
REQ-017 REQ: on first falling edge drive bit0; DATA: on each following falling edge drive next bit, LSB first, 3-bit counter; data value b drives ps2_data_oe=~b.
REQ-018 After bit7, next falling edge drives parity (PARITY); next falling edge releases data, i.e. stop bit 1 (STOP).
REQ-019 ACK: on the next falling edge sample synced data; 0 = acknowledged, 1 = ack_err pulse.
REQ-020 WAIT_IDLE: wait until synced clock and data are both 1, then pulse done (also after ack_err) and return to IDLE.
REQ-021 oe outputs SHALL change one clk cycle after the synchronised falling edge is detected.
REQ-022 From REQ through WAIT_IDLE, if TIMEOUT_CYC cycles pass with no falling edge (WAIT_IDLE: lines not both high), SHALL release both oe, pulse timeout_err, go to IDLE; no done.
REQ-023 Timeout counter SHALL reset on every falling edge and on state entry; width $clog2(TIMEOUT_CYC+1).
REQ-024 Falling edges in IDLE or INHIBIT SHALL be ignored.
REQ-025 done, ack_err, timeout_err SHALL never be high for more than one consecutive cycle; timeout_err and done mutually exclusive.

Reset
REQ-026 On rst_n low, immediately: state IDLE, ps2_clk_oe=0, ps2_data_oe=0, done=0, ack_err=0, timeout_err=0, captured byte 0, counters 0, synchronisers 1 (idle line); tx_ready=1 after release.
REQ-027 Reset mid-frame SHALL abort silently, releasing both lines with no status pulse.

Structure
REQ-028 State enum and odd-parity function SHALL live in shared package ps2_pkg, usable by the keyboard receiver.
REQ-029 SHALL instantiate sub-module ps2_sync_edge (2-flop synchroniser plus falling-edge detect) for the clock line; data line uses its synchroniser only.

Verification (bench: INHIBIT_CYC=20, TIMEOUT_CYC=200, device model clocks at 40-cycle period)
REQ-030 Send 0xED, device acks -> clk held low 20 cycles, data bits 1,0,1,1,0,1,1,1, parity 1, stop 1, done pulse, ack_err 0.
REQ-031 Send 0x01 -> parity bit 0 driven; send 0x00 -> parity 1; device-captured bytes match.
REQ-032 Device never pulls data low in ack slot -> ack_err pulse, then done, lines released.
REQ-033 Device never clocks after REQ -> timeout_err exactly 200 cycles after REQ entry, both oe 0, tx_ready 1.
REQ-034 rst_n asserted after bit 4 -> both oe 0 same cycle, no pulses, next send of 0xF4 completes normally.
REQ-035 tx_valid held high during a frame with changing tx_data -> only the byte captured at accept is transmitted.
